// File: rtl/adc_avg_decim.sv
// Four-channel block-averaging decimator: averages each ADC channel over
// windows of 2^LOG2_AVG samples and presents one result set per window.
module adc_avg_decim #(
  parameter int LOG2_AVG = 4,
  parameter int DW       = 16
) (
  input  logic          clk_adc,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_avg0,
  output logic [DW-1:0] m_avg1,
  output logic [DW-1:0] m_avg2,
  output logic [DW-1:0] m_avg3,
  output logic [3:0]    m_clip,
  output logic [15:0]   m_seq,
  output logic          ovf,
  input  logic          clr_ovf
);

  localparam int AW = DW + LOG2_AVG;
  localparam int CW = (LOG2_AVG > 0) ? LOG2_AVG : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG2_AVG) - 1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t state_q, state_d;

  logic signed [DW-1:0] din_s    [4];
  logic signed [AW-1:0] acc_p0   [4];
  logic signed [AW-1:0] acc_base [4];
  logic signed [AW-1:0] sum_p0   [4];
  logic [CW-1:0]        cnt_p0;
  logic [CW-1:0]        cnt_base;
  logic [3:0]           clip_p0;
  logic [3:0]           clip_win;
  logic                 last_p0;
  logic                 done_p0;

  logic [DW-1:0]        avg_p1 [4];
  logic [3:0]           clip_p1;
  logic [15:0]          seq_out_p1;
  logic [15:0]          seq_cnt;
  logic                 vld_p1;
  logic                 ovf_q;
  logic                 load_p1;
  logic                 drop_p1;

  function automatic logic signed [AW-1:0] sext(input logic signed [DW-1:0] x);
    return AW'(x);
  endfunction

  // Arithmetic shift floors toward minus infinity, so -0.25 becomes -1.
  function automatic logic [DW-1:0] avg_floor(input logic signed [AW-1:0] s);
    logic signed [AW-1:0] sh;
    sh = s >>> LOG2_AVG;
    return sh[DW-1:0];
  endfunction

  function automatic logic is_clip(input logic [DW-1:0] x);
    return (x == {1'b0, {(DW-1){1'b1}}}) || (x == {1'b1, {(DW-1){1'b0}}});
  endfunction

  assign din_s[0] = din0;
  assign din_s[1] = din1;
  assign din_s[2] = din2;
  assign din_s[3] = din3;

  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = ACC;
      ACC:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The sample arriving with the IDLE->ACC transition opens a fresh window.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      acc_base[i] = (state_q == ACC) ? acc_p0[i] : '0;
      sum_p0[i]   = acc_base[i] + sext(din_s[i]);
    end
    cnt_base = (state_q == ACC) ? cnt_p0 : '0;
    clip_win = ((state_q == ACC) ? clip_p0 : 4'b0000)
               | {is_clip(din_s[3]), is_clip(din_s[2]), is_clip(din_s[1]), is_clip(din_s[0])};
  end

  assign last_p0 = (cnt_base == CNT_LAST);
  assign done_p0 = en & last_p0;

  // ---- stage p0: accumulate ----
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) acc_p0[i] <= '0;
      cnt_p0  <= '0;
      clip_p0 <= '0;
    end else if (!en || last_p0) begin
      for (int i = 0; i < 4; i++) acc_p0[i] <= '0;
      cnt_p0  <= '0;
      clip_p0 <= '0;
    end else begin
      for (int i = 0; i < 4; i++) acc_p0[i] <= sum_p0[i];
      cnt_p0  <= cnt_base + CW'(1);
      clip_p0 <= clip_win;
    end
  end

  assign load_p1 = done_p0 & (~vld_p1 | m_ready);
  assign drop_p1 = done_p0 & vld_p1 & ~m_ready;

  // ---- stage p1: single-entry output register ----
  always_ff @(posedge clk_adc or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) avg_p1[i] <= '0;
      clip_p1    <= '0;
      seq_out_p1 <= '0;
      seq_cnt    <= '0;
      vld_p1     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      if (load_p1) begin
        for (int i = 0; i < 4; i++) avg_p1[i] <= avg_floor(sum_p0[i]);
        clip_p1    <= clip_win;
        seq_out_p1 <= seq_cnt;
        vld_p1     <= 1'b1;
      end else if (m_ready) begin
        vld_p1 <= 1'b0;
      end
      if (done_p0) seq_cnt <= seq_cnt + 16'd1;
      if (drop_p1)      ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

  assign m_valid = vld_p1;
  assign m_avg0  = avg_p1[0];
  assign m_avg1  = avg_p1[1];
  assign m_avg2  = avg_p1[2];
  assign m_avg3  = avg_p1[3];
  assign m_clip  = clip_p1;
  assign m_seq   = seq_out_p1;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_adc_avg_decim.sv
// Bench for adc_avg_decim: three instances (LOG2_AVG = 4, 2, 0) share one
// stimulus stream and are checked every cycle against a window-average model.
module tb_adc_avg_decim;

  logic        clk_adc = 1'b0;
  logic        rst_n;
  logic        en;
  logic        m_ready;
  logic        clr_ovf;
  logic [15:0] din [4];

  logic        vld_w  [3];
  logic [15:0] avg_w  [3][4];
  logic [3:0]  clip_w [3];
  logic [15:0] seq_w  [3];
  logic        ovf_w  [3];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_adc = ~clk_adc;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    adc_avg_decim #(.LOG2_AVG(g == 0 ? 4 : (g == 1 ? 2 : 0)), .DW(16)) u_dut (
      .clk_adc (clk_adc),
      .rst_n   (rst_n),
      .en      (en),
      .din0    (din[0]),
      .din1    (din[1]),
      .din2    (din[2]),
      .din3    (din[3]),
      .m_valid (vld_w[g]),
      .m_ready (m_ready),
      .m_avg0  (avg_w[g][0]),
      .m_avg1  (avg_w[g][1]),
      .m_avg2  (avg_w[g][2]),
      .m_avg3  (avg_w[g][3]),
      .m_clip  (clip_w[g]),
      .m_seq   (seq_w[g]),
      .ovf     (ovf_w[g]),
      .clr_ovf (clr_ovf)
    );
  end

  // Reference model: windows collected as plain sums, averaged by floor division.
  int          wsum  [3][4];
  int          wcnt  [3];
  logic [3:0]  wclip [3];
  logic        ev    [3];
  logic [15:0] eavg  [3][4];
  logic [3:0]  eclip [3];
  logic [15:0] eseq  [3];
  logic [15:0] seqc  [3];
  logic        eovf  [3];

  function automatic int nwin(input int k);
    return (k == 0) ? 16 : ((k == 1) ? 4 : 1);
  endfunction

  function automatic int floor_div(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n != 0) && (s < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [15:0] rnd_sample();
    int r;
    r = $urandom_range(0, 15);
    if (r == 0) return 16'h7FFF;
    if (r == 1) return 16'h8000;
    return 16'($urandom);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 4; c++) begin wsum[k][c] = 0; eavg[k][c] = '0; end
      wcnt[k] = 0; wclip[k] = '0; ev[k] = 1'b0; eclip[k] = '0;
      eseq[k] = '0; seqc[k] = '0; eovf[k] = 1'b0;
    end
  endtask

  task automatic model_update();
    logic hs, done, drop;
    int v, q;
    for (int k = 0; k < 3; k++) begin
      hs = ev[k] && m_ready;
      done = 1'b0;
      drop = 1'b0;
      if (!en) begin
        wcnt[k] = 0; wclip[k] = '0;
        for (int c = 0; c < 4; c++) wsum[k][c] = 0;
      end else begin
        for (int c = 0; c < 4; c++) begin
          v = int'($signed(din[c]));
          wsum[k][c] += v;
          if (din[c] == 16'h7FFF || din[c] == 16'h8000) wclip[k][c] = 1'b1;
        end
        wcnt[k]++;
        if (wcnt[k] == nwin(k)) begin
          done = 1'b1;
          if (!ev[k] || hs) begin
            for (int c = 0; c < 4; c++) begin
              q = floor_div(wsum[k][c], nwin(k));
              eavg[k][c] = q[15:0];
            end
            eclip[k] = wclip[k];
            eseq[k]  = seqc[k];
          end
          wcnt[k] = 0; wclip[k] = '0;
          for (int c = 0; c < 4; c++) wsum[k][c] = 0;
        end
      end
      if (done) begin
        if (!ev[k] || hs) ev[k] = 1'b1;
        else drop = 1'b1;
        seqc[k] = seqc[k] + 16'd1;
      end else if (hs) begin
        ev[k] = 1'b0;
      end
      if (drop) eovf[k] = 1'b1;
      else if (clr_ovf) eovf[k] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("i%0d_valid", k), 32'(vld_w[k]), 32'(ev[k]));
      chk($sformatf("i%0d_ovf", k), 32'(ovf_w[k]), 32'(eovf[k]));
      if (ev[k]) begin
        for (int c = 0; c < 4; c++)
          chk($sformatf("i%0d_avg%0d", k, c), 32'(avg_w[k][c]), 32'(eavg[k][c]));
        chk($sformatf("i%0d_clip", k), 32'(clip_w[k]), 32'(eclip[k]));
        chk($sformatf("i%0d_seq", k), 32'(seq_w[k]), 32'(eseq[k]));
      end
    end
  endtask

  task automatic chk_reset();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_i%0d_valid", k), 32'(vld_w[k]), 32'd0);
      chk($sformatf("rst_i%0d_ovf", k), 32'(ovf_w[k]), 32'd0);
      chk($sformatf("rst_i%0d_clip", k), 32'(clip_w[k]), 32'd0);
      chk($sformatf("rst_i%0d_seq", k), 32'(seq_w[k]), 32'd0);
      for (int c = 0; c < 4; c++)
        chk($sformatf("rst_i%0d_avg%0d", k, c), 32'(avg_w[k][c]), 32'd0);
    end
  endtask

  task automatic step();
    @(posedge clk_adc);
    model_update();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < 4; c++) din[c] = rnd_sample();
      step();
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    rst_n = 1'b1;
  endtask

  logic [15:0] prev0;

  initial begin
    rst_n = 1'b0; en = 1'b0; m_ready = 1'b0; clr_ovf = 1'b0;
    for (int c = 0; c < 4; c++) din[c] = '0;
    model_reset();
    #12;
    chk_reset();
    @(posedge clk_adc); #1;
    rst_n = 1'b1;

    // Constant inputs, LOG2_AVG=4: result 16 cycles after en rise, seq 0,1,2.
    din[0] = 16'h0100; din[1] = 16'hFF00; din[2] = 16'h1234; din[3] = 16'h0000;
    m_ready = 1'b1; en = 1'b1;
    run(15);
    chk("t1_not_yet", 32'(vld_w[0]), 32'd0);
    step();
    chk("t1_valid", 32'(vld_w[0]), 32'd1);
    chk("t1_avg0", 32'(avg_w[0][0]), 32'h0100);
    chk("t1_avg1", 32'(avg_w[0][1]), 32'hFF00);
    chk("t1_seq0", 32'(seq_w[0]), 32'd0);
    run(16);
    chk("t1_seq1", 32'(seq_w[0]), 32'd1);
    run(16);
    chk("t1_seq2", 32'(seq_w[0]), 32'd2);

    // LOG2_AVG=2: floor of -0.25, full-scale clip, then a clean window.
    en = 1'b0; for (int c = 0; c < 4; c++) din[c] = '0;
    step();
    en = 1'b1; din[0] = 16'hFFFF;
    step();
    din[0] = 16'h0000;
    run(3);
    chk("t2_floor", 32'(avg_w[1][0]), 32'hFFFF);
    din[0] = 16'h7FFF;
    run(4);
    chk("t2_sat_avg", 32'(avg_w[1][0]), 32'h7FFF);
    chk("t2_sat_clip", 32'(clip_w[1]), 32'h1);
    din[0] = 16'h0010;
    run(4);
    chk("t2_clean_clip", 32'(clip_w[1]), 32'h0);
    chk("t2_clean_avg", 32'(avg_w[1][0]), 32'h0010);

    // Back-pressure across two completions, then drain and clear ovf.
    pulse_reset();
    m_ready = 1'b0; en = 1'b1;
    run_rand(40);
    chk("t3_held_seq", 32'(seq_w[0]), 32'd0);
    chk("t3_ovf", 32'(ovf_w[0]), 32'd1);
    clr_ovf = 1'b1;
    run_rand(1);
    chk("t3_ovf_set_wins", 32'(ovf_w[2]), 32'd1);
    clr_ovf = 1'b0; m_ready = 1'b1;
    run_rand(1);
    run_rand(6);
    chk("t3_gap_seq", 32'(seq_w[0]), 32'd2);
    clr_ovf = 1'b1;
    run_rand(1);
    clr_ovf = 1'b0;
    chk("t3_ovf_clr", 32'(ovf_w[0]), 32'd0);

    // Partial window discarded on en drop.
    pulse_reset();
    m_ready = 1'b1; en = 1'b1;
    run_rand(5);
    en = 1'b0;
    run_rand(3);
    en = 1'b1;
    run_rand(15);
    chk("t4_no_partial", 32'(vld_w[0]), 32'd0);
    run_rand(1);
    chk("t4_valid", 32'(vld_w[0]), 32'd1);

    // Asynchronous reset mid-window while a result is pending.
    m_ready = 1'b0;
    run_rand(5);
    chk("t5_pending", 32'(vld_w[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset();
    rst_n = 1'b1; m_ready = 1'b1; en = 1'b1;
    run_rand(16);
    chk("t5_seq_restart", 32'(seq_w[0]), 32'd0);

    // Pass-through instance: avg equals din delayed one cycle.
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < 4; c++) din[c] = rnd_sample();
      prev0 = din[0];
      step();
      chk("t6_delay", 32'(avg_w[2][0]), 32'(prev0));
    end

    // Random en / m_ready / clr_ovf soak.
    for (int i = 0; i < 400; i++) begin
      en      = ($urandom_range(0, 15) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      clr_ovf = ($urandom_range(0, 15) == 0);
      run_rand(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
